// File: rtl/hs32_flash_pkg.sv
// Shared encodings for the hs32 SPI flash reader.
// Build option HS32_FLASH_FASTREAD_EN selects fast read (0x0B + dummy byte).
package hs32_flash_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CMD   = 3'd1;
  localparam logic [2:0] ST_ADDR  = 3'd2;
  localparam logic [2:0] ST_DUMMY = 3'd3;
  localparam logic [2:0] ST_DATA  = 3'd4;
  localparam logic [2:0] ST_DESEL = 3'd5;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;

  localparam int CMD_BITS   = 8;
  localparam int ADDR_BITS  = 24;
  localparam int DUMMY_BITS = 8;
  localparam int DATA_BITS  = 32;

  // Bytes arrive b0 first; the word is presented little-endian.
  function automatic logic [31:0] bswap32(
    input logic [31:0] w
  );
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/hs32_flash_sckgen.sv
// SPI mode-0 clock divider for the hs32 flash reader.
// rise/fall flag the clk edge on which sck changes level.
module hs32_flash_sckgen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic resetb,
  input  logic run,
  output logic sck,
  output logic rise,
  output logic fall
);

  logic [3:0] cnt;
  logic       edge_due;

  assign edge_due = run && (cnt == 4'(CLK_DIV - 1));
  assign rise     = edge_due && !sck;
  assign fall     = edge_due && sck;

  always_ff @(posedge clk) begin
    if (!resetb || !run) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (edge_due) begin
      cnt <= '0;
      sck <= !sck;
    end else begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/hs32_flash_reader.sv
// Single-bit SPI flash word reader (read 0x03, or fast read 0x0B
// with a dummy byte when HS32_FLASH_FASTREAD_EN is defined).
module hs32_flash_reader
  import hs32_flash_pkg::*;
#(
  parameter int CLK_DIV = 1,
  parameter int CS_IDLE = 2
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        req,
  input  logic [23:0] addr,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0,
  input  logic        flash_io1
);

`ifdef HS32_FLASH_FASTREAD_EN
  localparam logic [7:0] OPCODE    = OP_FAST_READ;
  localparam logic [2:0] ST_POST_A = ST_DUMMY;
  localparam int         POST_BITS = DUMMY_BITS;
`else
  localparam logic [7:0] OPCODE    = OP_READ;
  localparam logic [2:0] ST_POST_A = ST_DATA;
  localparam int         POST_BITS = DATA_BITS;
`endif

  logic [2:0]  state;
  logic [5:0]  bit_cnt;
  logic [31:0] tx_sr;
  logic [31:0] rx_sr;
  logic [7:0]  desel_cnt;
  logic        run;
  logic        rise;
  logic        fall;

  assign run       = (state != ST_IDLE) && (state != ST_DESEL);
  assign busy      = (state != ST_IDLE);
  assign flash_csb = !run;
  // Opcode and address share one shifter; it drains to zero by DUMMY/DATA.
  assign flash_io0 = tx_sr[31];

  hs32_flash_sckgen #(
    .CLK_DIV(CLK_DIV)
  ) u_sckgen (
    .clk   (clk),
    .resetb(resetb),
    .run   (run),
    .sck   (flash_clk),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      desel_cnt <= '0;
      rdata     <= '0;
      ack       <= 1'b0;
    end else begin
      ack <= 1'b0;
      if (rise && state == ST_DATA)
        rx_sr <= {rx_sr[30:0], flash_io1};
      if (state == ST_IDLE) begin
        if (req) begin
          tx_sr   <= {OPCODE, addr};
          bit_cnt <= 6'(CMD_BITS - 1);
          state   <= ST_CMD;
        end
      end else if (state == ST_DESEL) begin
        if (desel_cnt == 8'd0)
          state <= ST_IDLE;
        else
          desel_cnt <= desel_cnt - 8'd1;
      end else if (fall) begin
        tx_sr <= tx_sr << 1;
        if (bit_cnt != 6'd0) begin
          bit_cnt <= bit_cnt - 6'd1;
        end else begin
          unique case (1'b1)
            state == ST_CMD: begin
              state   <= ST_ADDR;
              bit_cnt <= 6'(ADDR_BITS - 1);
            end
            state == ST_ADDR: begin
              state   <= ST_POST_A;
              bit_cnt <= 6'(POST_BITS - 1);
            end
            state == ST_DUMMY: begin
              state   <= ST_DATA;
              bit_cnt <= 6'(DATA_BITS - 1);
            end
            default: begin
              state     <= ST_DESEL;
              desel_cnt <= 8'(CS_IDLE - 1);
              rdata     <= bswap32(rx_sr);
              ack       <= 1'b1;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_hs32_flash_reader.sv
// Directed bench for hs32_flash_reader with behavioural SPI flash models
// on a CLK_DIV=1 instance and a CLK_DIV=3 instance.
module tb_hs32_flash_reader;

`ifdef HS32_FLASH_FASTREAD_EN
  localparam int         NB  = 72;
  localparam logic [7:0] OPC = 8'h0B;
`else
  localparam int         NB  = 64;
  localparam logic [7:0] OPC = 8'h03;
`endif
  localparam int DS = NB - 32;

  logic clk = 1'b0;
  logic resetb = 1'b0;
  always #5 clk = ~clk;

  logic        req_a = 1'b0;
  logic [23:0] addr_a = '0;
  logic [31:0] rdata_a;
  logic        ack_a, busy_a, csb_a, sck_a, mosi_a;
  logic        miso_a = 1'b0;

  logic        req_b = 1'b0;
  logic [23:0] addr_b = '0;
  logic [31:0] rdata_b;
  logic        ack_b, busy_b, csb_b, sck_b, mosi_b;
  logic        miso_b = 1'b0;

  hs32_flash_reader #(.CLK_DIV(1), .CS_IDLE(2)) dut (
    .clk(clk), .resetb(resetb), .req(req_a), .addr(addr_a),
    .rdata(rdata_a), .ack(ack_a), .busy(busy_a),
    .flash_csb(csb_a), .flash_clk(sck_a),
    .flash_io0(mosi_a), .flash_io1(miso_a)
  );

  hs32_flash_reader #(.CLK_DIV(3), .CS_IDLE(2)) dut3 (
    .clk(clk), .resetb(resetb), .req(req_b), .addr(addr_b),
    .rdata(rdata_b), .ack(ack_b), .busy(busy_b),
    .flash_csb(csb_b), .flash_clk(sck_b),
    .flash_io0(mosi_b), .flash_io1(miso_b)
  );

  function automatic logic [7:0] mem(input logic [23:0] a);
    case (a)
      24'h000100: return 8'h11;
      24'h000101: return 8'h22;
      24'h000102: return 8'h33;
      24'h000103: return 8'h44;
      default:    return a[7:0] ^ 8'hA5;
    endcase
  endfunction

  function automatic logic fbit(input logic [23:0] a, input int d);
    logic [7:0] b;
    if (d < 0 || d >= 32) return 1'b0;
    b = mem(a + 24'(d / 8));
    return b[7 - (d % 8)];
  endfunction

  int          nr_a, nr_b;
  logic [71:0] hist_a, hist_b;
  logic [23:0] fadr_a, fadr_b;
  logic [7:0]  fcmd_a, fcmd_b;

  always @(negedge csb_a) begin nr_a = 0; hist_a = '0; end
  always @(posedge sck_a) if (!csb_a) begin
    hist_a = {hist_a[70:0], mosi_a};
    nr_a++;
    if (nr_a == 32) begin fadr_a = hist_a[23:0]; fcmd_a = hist_a[31:24]; end
  end
  always @(negedge sck_a) if (!csb_a) miso_a = fbit(fadr_a, nr_a - DS);

  always @(negedge csb_b) begin nr_b = 0; hist_b = '0; end
  always @(posedge sck_b) if (!csb_b) begin
    hist_b = {hist_b[70:0], mosi_b};
    nr_b++;
    if (nr_b == 32) begin fadr_b = hist_b[23:0]; fcmd_b = hist_b[31:24]; end
  end
  always @(negedge sck_b) if (!csb_b) miso_b = fbit(fadr_b, nr_b - DS);

  int viol = 0;
  always @(negedge clk) begin
    if (csb_a && mosi_a) viol++;
    if (csb_b && mosi_b) viol++;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // mode 1 pokes req/addr while busy to show both are ignored.
  task automatic run_a(input logic [23:0] a, input bit hold,
                       input int mode, output int k);
    @(negedge clk);
    req_a = 1'b1;
    addr_a = a;
    @(posedge clk); #1;
    if (!hold) req_a = 1'b0;
    k = 1;
    chk("cs_low_c1", csb_a, 0);
    chk("busy_c1", busy_a, 1);
    while (!ack_a && k < 2000) begin
      if (mode == 1 && k == 10) begin req_a = 1'b1; addr_a = 24'hABCDEF; end
      if (mode == 1 && k == 12) req_a = 1'b0;
      @(posedge clk); #1;
      k++;
    end
  endtask

  initial begin
    int k, j, hi, seen, r1, r2;
    bit prev;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_csb", csb_a, 1);
    chk("rst_sck", sck_a, 0);
    chk("rst_io0", mosi_a, 0);
    chk("rst_ack", ack_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_rdata", rdata_a, 0);
    @(negedge clk);
    resetb = 1'b1;

    run_a(24'h000100, 1'b0, 1, k);
    chk("ack_cycle", k, 1 + 2 * NB);
    chk("rdata", rdata_a, 32'h44332211);
    chk("opcode", fcmd_a, OPC);
    chk("addr_sent", fadr_a, 24'h000100);
    chk("csb_at_ack", csb_a, 1);
    chk("sck_at_ack", sck_a, 0);
    chk("busy_at_ack", busy_a, 1);
    @(posedge clk); #1;
    chk("ack_pulse", ack_a, 0);
    chk("desel_busy", busy_a, 1);
    @(posedge clk); #1;
    chk("idle_busy", busy_a, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("no_retrig", busy_a, 0);
    chk("no_retrig_cs", csb_a, 1);

    run_a(24'h000100, 1'b1, 0, k);
    chk("b2b_ack1", k, 1 + 2 * NB);
    j = 0;
    hi = 0;
    do begin
      @(posedge clk); #1;
      j++;
      if (csb_a && !ack_a) hi++;
    end while (!ack_a && j < 2000);
    req_a = 1'b0;
    chk("b2b_spacing", j, 1 + 2 * NB + 2);
    chk("b2b_cs_gap", hi >= 2, 1);
    chk("b2b_rdata", rdata_a, 32'h44332211);
    repeat (4) @(posedge clk);

    @(negedge clk);
    req_a = 1'b1;
    addr_a = 24'h000100;
    @(posedge clk); #1;
    req_a = 1'b0;
    k = 1;
    seen = 0;
    while (k < 80) begin
      @(posedge clk); #1;
      k++;
      if (ack_a) seen++;
    end
    chk("abort_busy", busy_a, 1);
    resetb = 1'b0;
    @(posedge clk); #1;
    chk("abort_csb", csb_a, 1);
    chk("abort_sck", sck_a, 0);
    chk("abort_rdata", rdata_a, 0);
    chk("abort_ack", ack_a, 0);
    chk("abort_idle", busy_a, 0);
    @(negedge clk);
    resetb = 1'b1;
    repeat (150) begin
      @(posedge clk); #1;
      if (ack_a) seen++;
    end
    chk("abort_no_ack", seen, 0);

    @(negedge clk);
    req_b = 1'b1;
    addr_b = 24'hFFFFFE;
    @(posedge clk); #1;
    req_b = 1'b0;
    k = 1;
    r1 = 0;
    r2 = 0;
    prev = sck_b;
    while (!ack_b && k < 4000) begin
      @(posedge clk); #1;
      k++;
      if (sck_b && !prev) begin
        if (r1 == 0) r1 = k;
        else if (r2 == 0) r2 = k;
      end
      prev = sck_b;
    end
    chk("slow_ack_cycle", k, 1 + 6 * NB);
    chk("slow_period", r2 - r1, 6);
    chk("slow_opcode", fcmd_b, OPC);
    chk("slow_addr", fadr_b, 24'hFFFFFE);
    chk("slow_rdata", rdata_b, 32'hA4A55A5B);
    repeat (4) @(posedge clk);
    chk("io0_idle_low", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hs32_flash_reader.md
HS32_FLASH_READER -- requirements
Module: hs32_flash_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1, meaning flash_clk half-period in clk cycles (legal range 1..15).
REQ-002 SHALL have parameter CS_IDLE, default 2, meaning minimum flash_csb high time between transactions, in clk cycles.
REQ-003 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port resetb  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port req  in  1  read request, sampled only in IDLE.
REQ-006 SHALL have port addr  in  24  byte address of the first byte, any alignment.
REQ-007 SHALL have port rdata  out  32  read word, valid while ack=1 and held until the next ack.
REQ-008 SHALL have port ack  out  1  one-cycle completion pulse.
REQ-009 SHALL have port busy  out  1  high from request acceptance until return to IDLE.
REQ-010 SHALL have ports flash_csb out 1, flash_clk out 1, flash_io0 out 1 (MOSI) and flash_io1 in 1 (MISO), using SPI mode 0 single-bit transfers.

Function
REQ-011 SHALL implement states IDLE, CMD (8 bits), ADDR (24 bits), DUMMY (8 bits, only when the macro is defined), DATA (32 bits), DESEL.
REQ-012 SHALL, in IDLE with req=1 at cycle 0, latch addr, set busy=1 and go to CMD; at cycle 1 flash_csb=0 and flash_io0 carries the opcode MSB.
REQ-013 SHALL spend 2*CLK_DIV cycles per bit: CLK_DIV cycles with flash_clk=0, then CLK_DIV cycles with flash_clk=1.
REQ-014 SHALL change flash_io0 only while flash_clk is low, and sample flash_io1 in the cycle flash_clk rises; all fields are sent and received MSB first.
REQ-015 SHALL send opcode 0x03, then the latched 24-bit address; changes on addr after acceptance have no effect.
REQ-016 SHALL assemble received bytes b0..b3 (b0 from the latched address) as rdata = {b3,b2,b1,b0}, i.e. little-endian.
REQ-017 SHALL, at cycle 1 + 2*CLK_DIV*N (N = total bits, 64 in read mode), drive flash_csb=1, flash_clk=0 and ack=1 with rdata updated, and enter DESEL.
REQ-018 SHALL hold DESEL for CS_IDLE cycles with busy=1, then return to IDLE with busy=0.
REQ-019 SHALL ignore req while busy=1; a req held high through DESEL is accepted on the first IDLE cycle.
REQ-020 SHALL transmit address 0xFFFFFF unchanged; wrap-around is the flash's concern, and the block performs no address arithmetic.
REQ-021 SHALL hold flash_io0=0 whenever flash_csb=1.

Reset
REQ-022 SHALL, on any clock edge with resetb=0 (including mid-transfer), set state=IDLE, flash_csb=1, flash_clk=0, flash_io0=0, ack=0, busy=0, rdata=0, and clear bit and divider counters.
REQ-023 SHALL never pulse ack for a transaction aborted by reset.

Configuration
REQ-024 SHALL, with HS32_FLASH_FASTREAD_EN defined, use opcode 0x0B and insert the DUMMY state (8 bit times, flash_io0=0, flash_io1 ignored), giving N=72.
REQ-025 SHALL, without HS32_FLASH_FASTREAD_EN, use opcode 0x03, have no DUMMY state, and use N=64.

Structure
REQ-026 SHALL take the state encoding, opcodes 0x03/0x0B and field bit counts (8/24/8/32) from the shared package hs32_flash_pkg.
REQ-027 SHALL place the flash_clk divider and the rise/fall strobe generation in sub-module hs32_flash_sckgen (inputs clk, resetb, run; outputs sck, rise, fall).

Verification
REQ-028 Basic read: flash holds 11 22 33 44 at 0x000100, CLK_DIV=1, req with addr=0x000100 -> io0 shifts 0x03 then 0x000100, ack at cycle 129, rdata=0x44332211.
REQ-029 Busy and address stability: req pulsed and addr set to 0xABCDEF while busy -> no second transaction starts, and the address sent is still 0x000100.
REQ-030 Back-to-back: req held high over two transactions -> flash_csb high for at least 2 cycles between them, and two acks spaced 131 cycles apart.
REQ-031 Abort: resetb=0 at cycle 80 (in DATA) -> next edge has flash_csb=1, flash_clk=0 and rdata=0, with no ack.
REQ-032 Fast read: HS32_FLASH_FASTREAD_EN defined, same data as REQ-028 -> opcode 0x0B, 8 dummy clocks, ack at cycle 145, rdata=0x44332211.
REQ-033 Slow clock: CLK_DIV=3, addr=0xFFFFFE -> flash_clk period of 6 cycles, address sent as 0xFFFFFE, ack at cycle 385.
